// File: rtl/add32_pkg.sv
// Shared constants and the result record for the 32-bit adder result buffer.
package add32_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    // One completed adder operation; cout sits above sum so {cout, sum} packs directly.
    typedef struct packed {
        logic         cout;
        logic [W-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/add32_result_buf_if.sv
// Adder-side and consumer-side signals of the adder result buffer.
// Optional overflow counter signals appear when ADD32_OVF_CNT_EN is defined.
interface add32_result_buf_if;
    import add32_pkg::*;

    logic          in_valid;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          add_stop;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [AW:0]   fill;
`ifdef ADD32_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
    logic          ovf_irq;

    modport master (
        output in_valid, add_sum, add_cout, out_ready,
        input  add_stop, out_valid, out_sum, out_cout, fill, ovf_cnt, ovf_irq
    );
    modport slave (
        input  in_valid, add_sum, add_cout, out_ready,
        output add_stop, out_valid, out_sum, out_cout, fill, ovf_cnt, ovf_irq
    );
`else
    modport master (
        output in_valid, add_sum, add_cout, out_ready,
        input  add_stop, out_valid, out_sum, out_cout, fill
    );
    modport slave (
        input  in_valid, add_sum, add_cout, out_ready,
        output add_stop, out_valid, out_sum, out_cout, fill
    );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, registered read pointer, no fall-through.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 8,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [Aw:0]      fill_o
);

    localparam logic [Aw:0] FullFill = (Aw + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Aw:0]      fill_q, fill_d;
    logic             do_push, do_pop;

    assign full_o  = (fill_q == FullFill);
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally at Depth; occupancy holds on simultaneous push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Pointer and occupancy state, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; contents need no reset since reads are qualified by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/add32_result_buf.sv
// Result buffer behind the 4-stage pipelined 32-bit adder: tracks real operations
// through the adder, captures completed results into a FIFO and stalls the adder
// when the FIFO is full. Optional overflow counter: define ADD32_OVF_CNT_EN.
module add32_result_buf
    import add32_pkg::*;
(
    input logic               clk,
    input logic               rst,
    add32_result_buf_if.slave bus
);

    logic [LAT-1:0] vld_q, vld_d;
    add_res_t       wdata, head;
    logic           push, pop, full, empty;
    logic [AW:0]    fill;

    // Stall comes only from registered occupancy, never from out_ready.
    assign bus.add_stop = full;

    assign wdata = '{cout: bus.add_cout, sum: bus.add_sum};
    assign push  = vld_q[LAT-1] && !full;
    assign pop   = !empty && bus.out_ready;

    // Valid pipe advances in lockstep with the adder and holds while it is stalled.
    always_comb begin
        vld_d = vld_q;
        if (!full) vld_d = {vld_q[LAT-2:0], bus.in_valid};
    end

    // Valid pipe state.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    sync_fifo #(
        .Width ($bits(add_res_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill)
    );

    assign bus.out_valid = !empty;
    assign bus.out_sum   = empty ? '0 : head.sum;
    assign bus.out_cout  = empty ? 1'b0 : head.cout;
    assign bus.fill      = fill;

`ifdef ADD32_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        ovf_irq_q, ovf_irq_d;

    // Saturating count of carry-out pushes; irq marks the push that saturates it.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        ovf_irq_d = 1'b0;
        if (push && bus.add_cout && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
            ovf_irq_d = (ovf_cnt_q == 16'hFFFE);
        end
    end

    // Counter and irq pulse state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            ovf_irq_q <= ovf_irq_d;
        end
    end

    assign bus.ovf_cnt = ovf_cnt_q;
    assign bus.ovf_irq = ovf_irq_q;
`endif

endmodule

// File: tb/tb_add32_result_buf.sv
// Self-checking bench for add32_result_buf. Models the upstream adder, keeps a
// queue of expected sums computed at issue time, and records delivered results.
module tb_add32_result_buf;
    import add32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add32_result_buf_if bus ();

    add32_result_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Upstream adder: LAT stages, stalls on add_stop.
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    add_res_t     pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (!bus.add_stop) begin
            pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.add_sum  = pipe[LAT-1].sum;
    assign bus.add_cout = pipe[LAT-1].cout;

    // Reference: every accepted operation yields exactly one result, in issue order.
    add_res_t exp_q [$];
    add_res_t got_q [$];
    int       got_t [$];
    int       cyc       = 0;
    bit       stop_seen = 1'b0;
    int       max_fill  = 0;
    int       gate_bad  = 0;
    int       irq_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.out_cout, bus.out_sum});
                got_t.push_back(cyc);
            end
            if (bus.add_stop) stop_seen <= 1'b1;
            if (int'(bus.fill) > max_fill) max_fill <= int'(bus.fill);
            if (!bus.out_valid && ((bus.out_sum != '0) || bus.out_cout)) gate_bad <= gate_bad + 1;
`ifdef ADD32_OVF_CNT_EN
            if (bus.ovf_irq) irq_cnt <= irq_cnt + 1;
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    // Present one operation and hold it until the adder accepts it.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        int guard = 0;
        bus.in_valid = 1'b1;
        op_a = a;
        op_b = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = !bus.add_stop;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc) begin
            exp_q.push_back({1'b0, a} + {1'b0, b});
        end else begin
            failures++;
            $display("FAIL issue_accept: operation not accepted within %0d cycles", guard);
        end
    endtask

    task automatic wait_drain(input int n);
        int guard = 0;
        while (got_q.size() < n && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        idle(3);
        checks++;
        if (got_q.size() != n) begin
            failures++;
            $display("FAIL drain_count: got %0d results, expected %0d", got_q.size(), n);
        end
    endtask

    task automatic compare_order(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL %s_missing[%0d]: expected %0h", tag, i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_data[%0d]: got %0h expected %0h", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        checks += 5;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
        if (bus.fill !== '0) begin failures++; $display("FAIL rst_fill: got %0d expected 0", bus.fill); end
        if (bus.add_stop !== 1'b0) begin failures++; $display("FAIL rst_add_stop: got %0b expected 0", bus.add_stop); end
        if (bus.out_sum !== '0) begin failures++; $display("FAIL rst_out_sum: got %0h expected 0", bus.out_sum); end
        if (bus.out_cout !== 1'b0) begin failures++; $display("FAIL rst_out_cout: got %0b expected 0", bus.out_cout); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_op();
        int lat = 0;
        clear_model();
        bus.out_ready = 1'b0;
        drive_op(32'h0000_00FF, 32'h0000_0001);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        checks += 4;
        if (lat != 5) begin failures++; $display("FAIL single_latency: got %0d cycles expected 5", lat); end
        if (bus.out_sum !== 32'h0000_0100) begin failures++; $display("FAIL single_sum: got %0h expected 100", bus.out_sum); end
        if (bus.out_cout !== 1'b0) begin failures++; $display("FAIL single_cout: got %0b expected 0", bus.out_cout); end
        if (bus.fill !== 4'd1) begin failures++; $display("FAIL single_fill: got %0d expected 1", bus.fill); end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain(1);
        compare_order("single");
    endtask

    task automatic test_stream();
        clear_model();
        bus.out_ready = 1'b1;
        stop_seen = 1'b0;
        max_fill = 0;
        for (int i = 0; i < 10; i++) drive_op($urandom, $urandom);
        wait_drain(10);
        compare_order("stream");
        for (int i = 1; i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] - got_t[i-1] != 1) begin
                failures++;
                $display("FAIL stream_gap[%0d]: got spacing %0d expected 1", i, got_t[i] - got_t[i-1]);
            end
        end
        checks += 2;
        if (stop_seen) begin failures++; $display("FAIL stream_stop: got add_stop high expected never"); end
        if (max_fill > 1) begin failures++; $display("FAIL stream_fill: got max %0d expected <=1", max_fill); end
    endtask

    task automatic test_backpressure();
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) drive_op($urandom, $urandom);
        idle(2);
        checks += 3;
        if (bus.add_stop !== 1'b1) begin failures++; $display("FAIL bp_stop: got %0b expected 1", bus.add_stop); end
        if (bus.fill !== 4'd8) begin failures++; $display("FAIL bp_fill: got %0d expected 8", bus.fill); end
        if (got_q.size() != 0) begin failures++; $display("FAIL bp_early: got %0d results expected 0", got_q.size()); end
        // in_valid asserted while stalled must not create a result.
        bus.in_valid = 1'b1;
        op_a = $urandom;
        op_b = $urandom;
        idle(3);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain(12);
        compare_order("bp");
    endtask

    task automatic test_full_pop();
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) drive_op($urandom, $urandom);
        idle(2);
        checks++;
        if (bus.fill !== 4'd8) begin failures++; $display("FAIL fp_full: got %0d expected 8", bus.fill); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.fill !== 4'd7) begin failures++; $display("FAIL fp_fill7: got %0d expected 7", bus.fill); end
        if (bus.add_stop !== 1'b0) begin failures++; $display("FAIL fp_stop0: got %0b expected 0", bus.add_stop); end
        idle(1);
        checks += 2;
        if (bus.fill !== 4'd8) begin failures++; $display("FAIL fp_refill: got %0d expected 8", bus.fill); end
        if (bus.add_stop !== 1'b1) begin failures++; $display("FAIL fp_stop1: got %0b expected 1", bus.add_stop); end
        bus.out_ready = 1'b1;
        wait_drain(12);
        compare_order("fp");
    endtask

    task automatic test_reset_mid();
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_op($urandom, $urandom);
        idle(1);
        checks++;
        if (bus.fill !== 4'd2) begin failures++; $display("FAIL rm_setup_fill: got %0d expected 2", bus.fill); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_model();
        checks += 2;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid: got %0b expected 0", bus.out_valid); end
        if (bus.fill !== '0) begin failures++; $display("FAIL rm_fill: got %0d expected 0", bus.fill); end
        bus.out_ready = 1'b1;
        idle(10);
        checks += 2;
        if (got_q.size() != 0) begin failures++; $display("FAIL rm_stale: got %0d results expected 0", got_q.size()); end
        if (bus.fill !== '0) begin failures++; $display("FAIL rm_fill_late: got %0d expected 0", bus.fill); end
    endtask

    task automatic test_empty();
        clear_model();
        bus.out_ready = 1'b1;
        idle(3);
        checks += 3;
        if (bus.fill !== '0) begin failures++; $display("FAIL empty_fill: got %0d expected 0", bus.fill); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL empty_valid: got %0b expected 0", bus.out_valid); end
        if (gate_bad != 0) begin failures++; $display("FAIL empty_gating: got %0d ungated cycles expected 0", gate_bad); end
    endtask

`ifdef ADD32_OVF_CNT_EN
    task automatic test_ovf();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_model();
        irq_cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_op(32'hFFFF_FFFF, 32'h0000_0001);
        wait_drain(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== {1'b1, 32'h0}) begin failures++; $display("FAIL ovf_result[%0d]: got %0h expected 100000000", i, got_q[i]); end
        end
        checks++;
        if (bus.ovf_cnt !== 16'd3) begin failures++; $display("FAIL ovf_cnt3: got %0d expected 3", bus.ovf_cnt); end
        clear_model();
        for (int i = 0; i < 65531; i++) drive_op(32'hFFFF_FFFF, 32'(1 + $urandom_range(0, 255)));
        idle(8);
        checks += 2;
        if (bus.ovf_cnt !== 16'hFFFE) begin failures++; $display("FAIL ovf_near: got %0h expected fffe", bus.ovf_cnt); end
        if (irq_cnt != 0) begin failures++; $display("FAIL ovf_irq_early: got %0d pulses expected 0", irq_cnt); end
        for (int i = 0; i < 3; i++) drive_op(32'hFFFF_FFFF, 32'h0000_0001);
        idle(8);
        checks += 2;
        if (bus.ovf_cnt !== 16'hFFFF) begin failures++; $display("FAIL ovf_sat: got %0h expected ffff", bus.ovf_cnt); end
        if (irq_cnt != 1) begin failures++; $display("FAIL ovf_irq: got %0d pulses expected 1", irq_cnt); end
        clear_model();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_op();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_empty();
`ifdef ADD32_OVF_CNT_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
